// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared constants and FSM state type for the slice-serial adder.
package adder_seq_pkg;
  localparam int CHUNK_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} adder_seq_state_t;
endpackage

// File: rtl/brent_kung_adder_4b.sv
// brent_kung_adder_4b: 4-bit Brent-Kung parallel-prefix adder with carry in/out.
module brent_kung_adder_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);
  logic [3:0] g, p, c;
  logic g10, p10, g32, p32;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g10 | (p10 & cin_i);
  assign c[3] = g[2] | (p[2] & c[2]);
  assign carry_o = g32 | (p32 & g10) | (p32 & p10 & cin_i);
  assign sum_o = p ^ c;
endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WIDTH-bit add/subtract streamed LSB-first through one shared 4-bit adder.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);
  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int IW = $clog2(NCHUNK);
  if (WIDTH % CHUNK_W != 0 || WIDTH < 8) begin : g_bad_width
    $error("adder_seq_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end
  adder_seq_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] op1_q, op2_q, sum_q;
  logic sub_q, c_q, ovf_q, last;
  logic [CHUNK_W-1:0] a, b, s;
  logic co;
  assign last = idx_q == IW'(NCHUNK - 1);
  assign a = op1_q[idx_q*CHUNK_W +: CHUNK_W];
  assign b = sub_q ? ~op2_q[idx_q*CHUNK_W +: CHUNK_W] : op2_q[idx_q*CHUNK_W +: CHUNK_W];
  brent_kung_adder_4b u_adder (
    .a_i    (a),
    .b_i    (b),
    .cin_i  (c_q),
    .sum_o  (s),
    .carry_o(co)
  );
  always_comb begin
    state_d = (state_q == IDLE && valid_i) ? BUSY :
              (state_q == BUSY && last)    ? DONE :
              (state_q == DONE && ready_i) ? IDLE : state_q;
    idx_d = (state_q == BUSY) ? idx_q + 1'b1 : '0;
  end
  // Subtraction is A + ~B + ~borrow, so the carry register holds the inverted borrow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == IDLE && valid_i) begin
        op1_q <= op1_i;
        op2_q <= op2_i;
        sub_q <= sub_i;
        c_q   <= sub_i ^ carry_i;
      end
      if (state_q == BUSY) begin
        sum_q[idx_q*CHUNK_W +: CHUNK_W] <= s;
        c_q <= co;
        if (last) ovf_q <= (a[3] == b[3]) && (s[3] != a[3]);
      end
    end
  end
  assign ready_o = state_q == IDLE;
  assign valid_o = state_q == DONE;
  assign sum_o   = sum_q;
  assign carry_o = sub_q ^ c_q;
  assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed vectors, handshake corner cases and randomized ops vs an arithmetic model.
module tb_adder_seq_ctrl;
  localparam int W = 16;
  localparam int NCH = W / 4;
  logic clk_i = 0, rst_ni = 1, valid_i = 0, ready_i = 0, carry_i = 0, sub_i = 0;
  logic [W-1:0] op1_i = '0, op2_i = '0;
  logic ready_o, valid_o, carry_o, ovf_o;
  logic [W-1:0] sum_o;
  int checks = 0, errors = 0, lat = 0;
  typedef struct {
    logic [W-1:0] a, b;
    logic c, s;
    logic [W-1:0] e_sum;
    logic e_c, e_ovf;
  } vec_t;
  vec_t vecs[6];

  adder_seq_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op1_i(op1_i), .op2_i(op2_i), .carry_i(carry_i), .sub_i(sub_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer add/subtract, result {ovf, carry/borrow, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic c, s);
    logic [W:0] r;
    logic o;
    if (!s) begin
      r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = {1'b0, a} - {1'b0, b} - (W+1)'(c);
      o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {o, r};
  endfunction

  task automatic start_op(input logic [W-1:0] a, b, input logic c, s);
    int n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) chk("ready_timeout", 0, 1);
    valid_i = 1; op1_i = a; op2_i = b; carry_i = c; sub_i = s;
    @(posedge clk_i);
    #1 valid_i = 0;
    lat = 0;
    while (!valid_o && lat < 50) begin
      @(posedge clk_i);
      #1 lat++;
    end
  endtask

  task automatic finish_op();
    ready_i = 1;
    @(posedge clk_i);
    #1 ready_i = 0;
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h1235, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0F0F, 16'h00F0, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
    #2 rst_ni = 0;
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_out", {sum_o, carry_o, ovf_o}, 0);
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);
      chk($sformatf("vec%0d_lat", i), lat, NCH);
      chk($sformatf("vec%0d_sum", i), sum_o, vecs[i].e_sum);
      chk($sformatf("vec%0d_carry", i), carry_o, vecs[i].e_c);
      chk($sformatf("vec%0d_ovf", i), ovf_o, vecs[i].e_ovf);
      finish_op();
      chk($sformatf("vec%0d_ready_after", i), ready_o, 1);
    end
    // Backpressure: DONE must hold and ignore new requests.
    start_op(16'h1234, 16'h1235, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      valid_i = 1; op1_i = 16'hAAAA; op2_i = 16'h5555; sub_i = 0;
      @(posedge clk_i);
      #1;
      chk($sformatf("bp%0d_hs", k), {ready_o, valid_o}, 2'b01);
      chk($sformatf("bp%0d_out", k), {sum_o, carry_o, ovf_o}, {16'hFFFF, 1'b1, 1'b0});
    end
    valid_i = 0;
    finish_op();
    chk("bp_release", {ready_o, valid_o}, 2'b10);
    repeat (6) @(posedge clk_i);
    #1 chk("bp_not_queued", {ready_o, valid_o}, 2'b10);
    // Reset while slice 2 is about to be processed.
    valid_i = 1; op1_i = 16'hFFFF; op2_i = 16'h0001; carry_i = 0; sub_i = 0;
    @(posedge clk_i);
    #1 valid_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 0;
    #1;
    chk("midrst_hs", {ready_o, valid_o}, 2'b10);
    chk("midrst_out", {sum_o, carry_o, ovf_o}, 0);
    @(negedge clk_i);
    rst_ni = 1;
    repeat (6) @(posedge clk_i);
    #1 chk("midrst_idle", {ready_o, valid_o}, 2'b10);
    start_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    chk("post_rst_lat", lat, NCH);
    chk("post_rst_sum", {sum_o, carry_o, ovf_o}, {16'h0003, 1'b0, 1'b0});
    finish_op();
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      m = model(ra, rb, rc, rs);
      start_op(ra, rb, rc, rs);
      chk($sformatf("rnd%0d_lat", i), lat, NCH);
      chk($sformatf("rnd%0d_res %h %h c%0b s%0b", i, ra, rb, rc, rs), {ovf_o, carry_o, sum_o}, m);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1 finish_op();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
